// File: rtl/sigma_delta_adc.sv
// Capture sequencer for sigma_delta_adc: pulses converter reset, drops STGS settling codes, buffers samples in a show-ahead FIFO.
// Optional SDADC_CTRL_SAT_CLAMP_EN: all-ones codes become 0 and are counted in sat_count.
module sigma_delta_adc_ctrl #(
  parameter int WDTH    = 18,
  parameter int STGS    = 2,
  parameter int RST_CYC = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_samples,
  output logic             adc_rst,
  input  logic [WDTH-1:0]  adc_output,
  input  logic             adc_valid,
  output logic [WDTH-1:0]  m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] sat_count
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCW = $clog2(DEPTH + 1);
  localparam int RCW = $clog2(RST_CYC + 1);
  localparam int SCW = (STGS > 0) ? $clog2(STGS + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_SETTLE, S_CAPTURE, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [RCW-1:0]   r_rst_cnt;
  logic [SCW-1:0]   r_settle_cnt;
  logic [CNT_W-1:0] r_remain;
  logic             r_done, r_overflow;
  logic             w_done_nxt, w_flush, w_start_ok;
  logic [WDTH-1:0]  r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr, w_rptr_inc;
  logic [OCW-1:0]   r_count, w_count_nxt;
  logic [WDTH-1:0]  r_m_data, w_push_dat;
  logic             r_m_valid, w_cap_vld, w_push, w_pop, w_load_in;

  assign w_start_ok  = (r_state == S_IDLE) && start && (num_samples != '0);
  assign w_cap_vld   = (r_state == S_CAPTURE) && adc_valid && !abort;
  assign w_pop       = r_m_valid && m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push      = w_cap_vld && ((r_count != OCW'(DEPTH)) || w_pop);
  assign w_count_nxt = r_count + OCW'(w_push) - OCW'(w_pop);
  assign w_load_in   = w_push && ((r_count == '0) || ((r_count == OCW'(1)) && w_pop));
  assign w_rptr_inc  = r_rptr + PW'(1);

`ifdef SDADC_CTRL_SAT_CLAMP_EN
  logic             w_all_ones;
  logic [CNT_W-1:0] r_sat_count;
  assign w_all_ones = &adc_output;
  assign w_push_dat = w_all_ones ? '0 : adc_output;
  assign sat_count  = r_sat_count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat_count <= '0;
    end else if (w_start_ok) begin
      r_sat_count <= '0;
    end else if (w_cap_vld && w_all_ones && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + CNT_W'(1);
    end
  end
`else
  assign w_push_dat = adc_output;
  assign sat_count  = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_samples == '0) w_done_nxt = 1'b1;
          else                   w_state_nxt = S_HOLD;
        end
      end
      S_HOLD:    if (r_rst_cnt == RCW'(1)) w_state_nxt = (STGS == 0) ? S_CAPTURE : S_SETTLE;
      S_SETTLE:  if (adc_valid && (r_settle_cnt == SCW'(STGS - 1))) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_cap_vld && (r_remain == CNT_W'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (r_count == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default:   w_state_nxt = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && abort) begin
      w_state_nxt = S_IDLE;
      w_done_nxt  = 1'b1;
      w_flush     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done       <= 1'b0;
      r_rst_cnt    <= '0;
      r_settle_cnt <= '0;
      r_remain     <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_start_ok) begin
        r_rst_cnt    <= RCW'(RST_CYC);
        r_settle_cnt <= '0;
        r_remain     <= num_samples;
        r_overflow   <= 1'b0;
      end else begin
        if (r_state == S_HOLD) r_rst_cnt <= r_rst_cnt - RCW'(1);
        if ((r_state == S_SETTLE) && adc_valid) r_settle_cnt <= r_settle_cnt + SCW'(1);
        if (w_cap_vld) r_remain <= r_remain - CNT_W'(1);
        if (w_cap_vld && !w_push) r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_dat;
  end

  // Occupancy counts the output register as one of the DEPTH entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_flush) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= w_rptr_inc;
      r_count   <= w_count_nxt;
      r_m_valid <= (w_count_nxt != '0);
      if (w_load_in)                          r_m_data <= w_push_dat;
      else if (w_pop && (w_count_nxt != '0)) r_m_data <= r_mem[w_rptr_inc];
    end
  end

  assign adc_rst  = !((r_state == S_SETTLE) || (r_state == S_CAPTURE));
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign m_data   = r_m_data;
  assign m_valid  = r_m_valid;
endmodule

// File: tb/tb_sigma_delta_adc_ctrl.sv
// Scoreboard bench for sigma_delta_adc_ctrl: randomized captures, overflow, full push+pop, abort,
// zero-length request, all-ones codes and asynchronous reset mid-capture.
module tb_sigma_delta_adc_ctrl;
  localparam int WDTH    = 18;
  localparam int STGS    = 2;
  localparam int RST_CYC = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort;
  logic [CNT_W-1:0] num_samples;
  logic             adc_rst;
  logic [WDTH-1:0]  adc_output;
  logic             adc_valid;
  logic [WDTH-1:0]  m_data;
  logic             m_valid, m_ready;
  logic             busy, done, overflow;
  logic [CNT_W-1:0] sat_count;

  int checks = 0;
  int errors = 0;
  logic [WDTH-1:0] sb_q[$];

  always #5 clk = ~clk;

  sigma_delta_adc_ctrl #(
    .WDTH(WDTH), .STGS(STGS), .RST_CYC(RST_CYC), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
    .adc_rst(adc_rst), .adc_output(adc_output), .adc_valid(adc_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .overflow(overflow), .sat_count(sat_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic budget_fail(input string name, input int cyc);
    checks++;
    errors++;
    $display("FAIL %s: waited %0d cycles without completion", name, cyc);
  endtask

  function automatic bit rnd(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  function automatic logic [WDTH-1:0] rnd_dat();
    return WDTH'($urandom);
  endfunction

  function automatic logic [WDTH-1:0] model_dat(input logic [WDTH-1:0] x);
`ifdef SDADC_CTRL_SAT_CLAMP_EN
    return (&x) ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Monitor: every handshake pops the scoreboard; m_valid must track model occupancy
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst && (m_valid || (sb_q.size() != 0))) chk("m_valid", m_valid, sb_q.size() != 0);
      if (rst && m_valid && m_ready && (sb_q.size() != 0)) chk("m_data", m_data, sb_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One clock: drive at negedge, check control outputs mid-cycle, return just after posedge
  task automatic step(input logic st, input logic ab, input logic [CNT_W-1:0] ns,
                      input logic av, input logic [WDTH-1:0] ad, input logic rd,
                      input logic e_rst, input logic e_busy, input logic e_done);
    @(negedge clk);
    start = st; abort = ab; num_samples = ns;
    adc_valid = av; adc_output = ad; m_ready = rd;
    #2;
    chk("adc_rst", adc_rst, e_rst);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_adc_rst", adc_rst, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_sat_count", sat_count, '0);
  endtask

  // rdy_pct < 0: consumer ready only when the FIFO is full
  task automatic capture(input int n, input int rdy_pct, input int vld_pct, input int sat_first,
                         input int abort_at, input int drain_pct);
    int seen, got, occ, cyc, exp_sat;
    bit ovf, ab, av, rd, pop, aborted, stuck;
    logic [WDTH-1:0] ad;
    seen = 0; got = 0; exp_sat = 0; cyc = 0;
    ovf = 0; aborted = 0; stuck = 0;
    step(1'b1, rnd(50), CNT_W'(n), rnd(50), rnd_dat(), rnd(50), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < RST_CYC; i++)
      step(1'b0, 1'b0, '0, rnd(50), rnd_dat(), rnd(50), 1'b1, 1'b1, 1'b0);
    while ((got < n) && !aborted && !stuck) begin
      av = rnd(vld_pct);
      ad = rnd_dat();
      if (av && (seen >= STGS) && (got < sat_first)) ad = '1;
      rd = (rdy_pct < 0) ? (sb_q.size() == DEPTH) : rnd(rdy_pct);
      ab = (got == abort_at);
      occ = sb_q.size();
      pop = (occ > 0) && rd;
      step(1'b0, ab, '0, av, ad, rd, 1'b0, 1'b1, 1'b0);
      if (ab) begin
        sb_q.delete();
        aborted = 1;
      end else if (av) begin
        if (seen < STGS) seen++;
        else begin
          got++;
`ifdef SDADC_CTRL_SAT_CLAMP_EN
          if (&ad) exp_sat++;
`endif
          if ((occ < DEPTH) || pop) sb_q.push_back(model_dat(ad));
          else ovf = 1;
        end
      end
      cyc++;
      if (cyc > 2000) stuck = 1;
    end
    if (stuck) budget_fail("run_budget", cyc);
    else if (aborted) begin
      step(1'b0, 1'b0, '0, rnd(50), rnd_dat(), rnd(50), 1'b1, 1'b0, 1'b1);
    end else begin
      cyc = 0;
      while ((sb_q.size() != 0) && (cyc < 500)) begin
        step(1'b0, 1'b0, '0, rnd(50), rnd_dat(), rnd(drain_pct), 1'b1, 1'b1, 1'b0);
        cyc++;
      end
      if (cyc >= 500) budget_fail("drain_budget", cyc);
      step(1'b0, 1'b0, '0, rnd(50), rnd_dat(), rnd(50), 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, rnd(50), rnd_dat(), rnd(50), 1'b1, 1'b0, 1'b1);
    end
    chk("overflow", overflow, ovf);
    chk("sat_count", sat_count, CNT_W'(exp_sat));
  endtask

  task automatic zero_len();
    step(1'b1, 1'b0, '0, 1'b1, rnd_dat(), 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, rnd_dat(), 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, rnd_dat(), 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic reset_mid();
    logic [WDTH-1:0] ad;
    step(1'b1, 1'b0, CNT_W'(10), 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < RST_CYC; i++)
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < STGS + 2; i++) begin
      ad = rnd_dat();
      step(1'b0, 1'b0, '0, 1'b1, ad, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i >= STGS) sb_q.push_back(model_dat(ad));
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, rp, vp, sf, ap, dp;
    rst = 1'b0; start = 1'b0; abort = 1'b0; num_samples = '0;
    adc_valid = 1'b0; adc_output = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    capture(3, 100, 60, 0, -1, 100);
    capture(6, 0, 100, 0, -1, 100);
    capture(8, -1, 100, 0, -1, 100);
    capture(10, 100, 100, 0, 2, 100);
    capture(5, 100, 100, 0, -1, 100);
    capture(4, 50, 70, 2, -1, 100);
    zero_len();
    for (int k = 0; k < 10; k++) begin
      n  = int'($urandom_range(9, 1));
      rp = int'($urandom_range(100, 20));
      vp = int'($urandom_range(100, 30));
      sf = int'($urandom_range(2));
      ap = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1;
      dp = int'($urandom_range(100, 40));
      capture(n, rp, vp, sf, ap, dp);
    end
    reset_mid();
    capture(2, 100, 100, 0, -1, 100);
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
